acumulador_mem_read_master: RTL and testbench
=============================================

Name: acumulador_mem_read_master

Overview:
Avalon-MM read master that sweeps a block of consecutive words out of the on-chip program/data memory slave and presents them on a ready/valid stream. It also accumulates a 32-bit running sum of the words it reads. It sits between the system's on-chip RAM (single port, no waitrequest, fixed read latency) and a downstream accumulator/consumer. Credit-based issue guarantees no returned word is ever dropped, even under backpressure.

Parameters:
ADDR_W, 14, word-address width (matches 16384-word memory)
DATA_W, 32, data/readdata width
LEN_W, 15, transfer-length width in words (max 16384)
READ_LATENCY, 1, cycles from address cycle to valid avm_readdata
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  cancel active transfer
base_addr  in  ADDR_W  first word address, latched on start
length  in  LEN_W  words to read, latched on start
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse, transfer complete and stream drained
checksum  out  DATA_W  sum mod 2^DATA_W of words read; stable while not busy
avm_address  out  ADDR_W  memory word address
avm_chipselect  out  1  read strobe (one word per high cycle)
avm_write  out  1  constant 0
avm_byteenable  out  DATA_W/8  constant all ones
avm_readdata  in  DATA_W  memory read data
st_data  out  DATA_W  stream word
st_valid  out  1  stream word valid
st_ready  in  1  sink accepts word when st_valid&st_ready

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, st_valid, avm_chipselect, avm_address, checksum = 0; FIFO empty; in-flight tags cleared. Outputs go low immediately when reset_n falls, not at the next edge.
- States: IDLE, READ, DRAIN.
- IDLE, start=1 and length!=0: latch base/length, clear issued count and checksum, busy=1, go READ.
- IDLE, start=1 and length=0: done=1 next cycle; no chipselect; checksum=0; stay IDLE.
- start while busy: ignored.
- READ: assert avm_chipselect with avm_address = base + issued (mod 2^ADDR_W, so the sweep wraps) when issued<length and fifo_count + inflight < FIFO_DEPTH. Registered outputs: a start in cycle 0 gives first chipselect in cycle 1.
- Return path: a READ_LATENCY-deep valid-tag shift register. Tagged avm_readdata is captured at the edge ending cycle t+READ_LATENCY, pushed into the FIFO, and added to checksum in the same edge.
- FIFO: st_valid = not empty. A pop occurs on st_valid&st_ready. Push and pop in the same cycle are allowed when full or empty. Order is preserved.
- When issued reaches length: go DRAIN.
- DRAIN: when inflight=0 and FIFO empty, pulse done for 1 cycle, clear busy, go IDLE.
- Timing with st_ready=1, READ_LATENCY=1, length N: chipselect in cycles 1..N, st_valid in cycles 3..N+2, done in cycle N+3. Throughput is one word per cycle.
- abort (READ or DRAIN): stop issuing, discard in-flight returns, flush FIFO. Next cycle st_valid=0, busy=0, state IDLE, no done pulse, checksum holds its partial value. abort in IDLE has no effect. If abort and start arrive in the same IDLE cycle, start wins.
- Checksum width: wraps modulo 2^DATA_W, no saturation.

Decomposition:
- Package acumulador_mem_pkg: state enum (IDLE/READ/DRAIN), default widths, the FIFO_DEPTH>=READ_LATENCY+2 check constant.
- Sub-module acumulador_stream_fifo: parameterised synchronous FIFO with count output and flush input, reset by the same reset_n. The FSM, issue logic, tag pipeline and checksum live in the top module.

Test Plan:
1. Memory word k = k+1. start with base=0, length=4, st_ready=1 -> chipselect cycles 1-4 at addresses 0,1,2,3; st_data 1,2,3,4 in cycles 3-6; done in cycle 7; checksum=10.
2. start with length=0 -> done in cycle 1; chipselect never asserted; checksum=0; busy stays 0.
3. base=0, length=8, st_ready=0 for 10 cycles then 1 -> exactly 4 chipselects before stall (FIFO_DEPTH); all 8 words delivered in order; checksum=36; done after the last pop.
4. base=16383, length=3 -> addresses 16383, 0, 1; st_data = mem[16383], 1, 2.
5. abort in cycle 3 of a length-8 transfer with st_ready=0 -> st_valid=0 and busy=0 the next cycle; no done pulse. A following start with base=0, length=2 delivers 1,2 with checksum=3. A start pulsed mid-transfer is ignored.
6. reset_n driven low asynchronously mid-READ -> chipselect, st_valid and busy drop without a clock edge. After release, IDLE with checksum=0.

Source files
------------

// File: rtl/acumulador_mem_pkg.sv
// Shared types and default sizing for the accumulator memory read master.
package acumulador_mem_pkg;

  localparam int unsigned AddrWDef       = 14;
  localparam int unsigned DataWDef       = 32;
  localparam int unsigned LenWDef        = 15;
  localparam int unsigned ReadLatencyDef = 1;
  localparam int unsigned FifoDepthDef   = 4;

  // The buffer must absorb every word still in the memory pipeline plus the
  // request being launched and the one being decided, or returns get dropped.
  localparam bit FifoDepthOkDef = FifoDepthDef >= ReadLatencyDef + 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  function automatic bit fifo_depth_ok(input int unsigned depth, input int unsigned latency);
    return depth >= latency + 2;
  endfunction

endpackage

// File: rtl/acumulador_mem_read_master_if.sv
// Avalon-MM read port and ready/valid output stream of the read master.
interface acumulador_mem_read_master_if #(
  parameter int unsigned ADDR_W = acumulador_mem_pkg::AddrWDef,
  parameter int unsigned DATA_W = acumulador_mem_pkg::DataWDef
);

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable,
    input  avm_readdata,
    output st_data, st_valid,
    input  st_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable,
    output avm_readdata,
    input  st_data, st_valid,
    output st_ready
  );

endinterface

// File: rtl/acumulador_mem_read_master_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
module acumulador_stream_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a word when one leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/acumulador_mem_read_master.sv
// Sweeps a block of memory words onto a ready/valid stream and sums them.
module acumulador_mem_read_master
  import acumulador_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDef,
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned LEN_W        = LenWDef,
  parameter int unsigned READ_LATENCY = ReadLatencyDef,
  parameter int unsigned FIFO_DEPTH   = FifoDepthDef
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  acumulador_mem_read_master_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if (!fifo_depth_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_cfg_err
    $error("FIFO_DEPTH must be at least READ_LATENCY+2");
  end

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, cs_q, cs_d;
  logic [ADDR_W-1:0]       addr_q, addr_d, base_q, base_d;
  logic [LEN_W-1:0]        len_q, len_d, issued_q, issued_d;
  logic [DATA_W-1:0]       csum_q, csum_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [CntW-1:0]         fifo_count;
  logic                    fifo_empty, flush, push, pop, capture, issue_ok, drained;
  logic [31:0]             outstanding;

  assign capture = tag_q[READ_LATENCY-1];
  assign pop     = bus.st_valid & bus.st_ready;

  // Credit check: every word already requested must have a FIFO slot waiting.
  assign outstanding = 32'(fifo_count) + 32'(cs_q) + 32'($countones(tag_q));
  assign issue_ok    = outstanding < FIFO_DEPTH;
  assign drained     = !cs_q && (tag_q == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_d     = 1'b0;
    addr_d   = addr_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    csum_d   = capture ? csum_q + bus.avm_readdata : csum_q;
    flush    = 1'b0;
    push     = capture;
    tag_d    = '0;
    tag_d[0] = cs_q;
    for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];

    case (state_q)
      StIdle: begin
        if (start) begin
          csum_d = '0;
          if (length != '0) begin
            // First request is launched straight from the start edge.
            base_d   = base_addr;
            len_d    = length;
            addr_d   = base_addr;
            cs_d     = 1'b1;
            issued_d = LEN_W'(1);
            busy_d   = 1'b1;
            state_d  = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead, StDrain: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          flush   = 1'b1;
          push    = 1'b0;
          csum_d  = csum_q;
          tag_d   = '0;
        end else if (state_q == StRead) begin
          if (issued_q == len_q) begin
            state_d = StDrain;
          end else if (issue_ok) begin
            cs_d     = 1'b1;
            addr_d   = base_q + issued_q[ADDR_W-1:0];
            issued_d = issued_q + LEN_W'(1);
          end
        end else if (drained) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      csum_q   <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      csum_q   <= csum_d;
      tag_q    <= tag_d;
    end
  end

  acumulador_stream_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (bus.avm_readdata),
    .pop_i   (pop),
    .rdata_o (bus.st_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.st_valid       = ~fifo_empty;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_write      = 1'b0;
  assign bus.avm_byteenable = '1;
  assign busy               = busy_q;
  assign done               = done_q;
  assign checksum           = csum_q;

endmodule

// File: tb/tb_acumulador_mem_read_master.sv
// Self-checking bench: memory model, event log and per-scenario checks.
module tb_acumulador_mem_read_master;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LW = 15;
  localparam int DEPTH = 4;
  localparam int MEMW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy, done;
  logic [DW-1:0] checksum;

  acumulador_mem_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  acumulador_mem_read_master #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .LEN_W        (LW),
    .READ_LATENCY (1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [DW-1:0] mem [MEMW];
  always @(posedge clk) if (bus.avm_chipselect) bus.avm_readdata <= mem[bus.avm_address];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            cs_cyc_q[$];
  logic [AW-1:0] cs_addr_q[$];
  int            pop_cyc_q[$];
  logic [DW-1:0] pop_data_q[$];
  int            done_cyc_q[$];
  int            out_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_chipselect) begin
        cs_cyc_q.push_back(cyc - base_cyc);
        cs_addr_q.push_back(bus.avm_address);
      end
      out_q.push_back(cs_cyc_q.size() - pop_cyc_q.size());
      if (bus.st_valid && bus.st_ready) begin
        pop_cyc_q.push_back(cyc - base_cyc);
        pop_data_q.push_back(bus.st_data);
      end
      if (done) done_cyc_q.push_back(cyc - base_cyc);
    end
  end

  task automatic clear_log();
    cs_cyc_q.delete(); cs_addr_q.delete(); pop_cyc_q.delete();
    pop_data_q.delete(); done_cyc_q.delete(); out_q.delete();
  endtask

  // mode 0: always ready, 1: random, 2: stalled for cycles 0..9
  task automatic set_ready(input int mode, input int k);
    case (mode)
      0: bus.st_ready = 1'b1;
      1: bus.st_ready = 1'($urandom_range(0, 1));
      default: bus.st_ready = (k < 10) ? 1'b0 : 1'b1;
    endcase
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l, input int mode);
    @(posedge clk); #1;
    clear_log();
    base_cyc = cyc;
    start = 1'b1; base_addr = b; length = l;
    set_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    set_ready(mode, 1);
  endtask

  task automatic wait_done(input int mode, input int budget);
    int k = 1;
    while (done_cyc_q.size() == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      set_ready(mode, k);
    end
    total++;
    if (done_cyc_q.size() == 0) begin
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, bus.st_valid, bus.avm_chipselect} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b required 0000",
               {busy, done, bus.st_valid, bus.avm_chipselect});
    end
    total++;
    if (bus.avm_address !== '0 || checksum !== '0) begin
      bad++;
      $display("FAIL reset_regs: got addr=%0d sum=%0d required 0/0", bus.avm_address, checksum);
    end
    total++;
    if (bus.avm_write !== 1'b0 || bus.avm_byteenable !== 4'hf) begin
      bad++;
      $display("FAIL avm_consts: got write=%b be=%h required 0/f",
               bus.avm_write, bus.avm_byteenable);
    end
  endtask

  task automatic test_basic();
    start_xfer(14'd0, 15'd4, 0);
    wait_done(0, 100);
    total++;
    if (cs_cyc_q.size() != 4 || pop_data_q.size() != 4) begin
      bad++;
      $display("FAIL basic_counts: got cs=%0d pops=%0d required 4/4",
               cs_cyc_q.size(), pop_data_q.size());
    end
    for (int i = 0; i < cs_cyc_q.size() && i < 4; i++) begin
      total++;
      if (cs_cyc_q[i] != i + 1 || cs_addr_q[i] !== AW'(i)) begin
        bad++;
        $display("FAIL basic_cs[%0d]: got cyc=%0d addr=%0d required %0d/%0d",
                 i, cs_cyc_q[i], cs_addr_q[i], i + 1, i);
      end
    end
    for (int i = 0; i < pop_data_q.size() && i < 4; i++) begin
      total++;
      if (pop_cyc_q[i] != i + 3 || pop_data_q[i] !== DW'(i + 1)) begin
        bad++;
        $display("FAIL basic_st[%0d]: got cyc=%0d data=%0d required %0d/%0d",
                 i, pop_cyc_q[i], pop_data_q[i], i + 3, i + 1);
      end
    end
    total++;
    if (done_cyc_q.size() == 0 || done_cyc_q[0] != 7) begin
      bad++;
      $display("FAIL basic_done_cycle: got %0d required 7",
               done_cyc_q.size() ? done_cyc_q[0] : -1);
    end
    total++;
    if (checksum !== 32'd10 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_sum: got sum=%0d busy=%b required 10/0", checksum, busy);
    end
  endtask

  task automatic test_zero_length();
    start_xfer(14'd5, 15'd0, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got done=%b busy=%b required 1/0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cs_cyc_q.size() != 0 || checksum !== '0 || done_cyc_q.size() != 1) begin
      bad++;
      $display("FAIL zero_after: got cs=%0d sum=%0d dones=%0d required 0/0/1",
               cs_cyc_q.size(), checksum, done_cyc_q.size());
    end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    start_xfer(14'd0, 15'd8, 2);
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk); #1;
      set_ready(2, k);
    end
    total++;
    if (cs_cyc_q.size() != DEPTH) begin
      bad++;
      $display("FAIL bp_stall_cs: got %0d required %0d", cs_cyc_q.size(), DEPTH);
    end
    wait_done(0, 200);
    for (int i = 0; i < 8; i++)
      if (i >= pop_data_q.size() || pop_data_q[i] !== DW'(i + 1)) errs++;
    total++;
    if (errs != 0 || pop_data_q.size() != 8) begin
      bad++;
      $display("FAIL bp_order: got %0d wrong of %0d words required 0 of 8",
               errs, pop_data_q.size());
    end
    total++;
    if (checksum !== 32'd36) begin
      bad++;
      $display("FAIL bp_sum: got %0d required 36", checksum);
    end
    total++;
    if (done_cyc_q.size() == 0 || pop_cyc_q.size() == 0 ||
        done_cyc_q[0] != pop_cyc_q[pop_cyc_q.size()-1] + 1) begin
      bad++;
      $display("FAIL bp_done_after_pop: got done=%0d last_pop=%0d required last_pop+1",
               done_cyc_q.size() ? done_cyc_q[0] : -1,
               pop_cyc_q.size() ? pop_cyc_q[pop_cyc_q.size()-1] : -1);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [3];
    logic [DW-1:0] exp_d [3];
    start_xfer(14'd16383, 15'd3, 0);
    wait_done(0, 100);
    for (int i = 0; i < 3; i++) begin
      exp_a[i] = AW'((16383 + i) % MEMW);
      exp_d[i] = mem[(16383 + i) % MEMW];
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= cs_addr_q.size() || i >= pop_data_q.size() ||
          cs_addr_q[i] !== exp_a[i] || pop_data_q[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL wrap[%0d]: got addr=%0d data=%0d required %0d/%0d", i,
                 i < cs_addr_q.size() ? int'(cs_addr_q[i]) : -1,
                 i < pop_data_q.size() ? pop_data_q[i] : 0, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] held;
    start_xfer(14'd0, 15'd8, 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 14'd100; length = 15'd5;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (bus.st_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: got valid=%b busy=%b required 1/1", bus.st_valid, busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (bus.st_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_next: got valid=%b busy=%b required 0/0", bus.st_valid, busy);
    end
    held = checksum;
    bus.st_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cyc_q.size() != 0 || checksum !== held || bus.st_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: got dones=%0d sum=%0d required 0/%0d",
               done_cyc_q.size(), checksum, held);
    end
    total++;
    if (cs_cyc_q.size() != 3 || cs_addr_q[0] !== 14'd0 || cs_addr_q[2] !== 14'd2) begin
      bad++;
      $display("FAIL abort_issue: got %0d chipselects required 3 at 0,1,2", cs_cyc_q.size());
    end
    start_xfer(14'd0, 15'd2, 0);
    wait_done(0, 100);
    total++;
    if (pop_data_q.size() != 2 || pop_data_q[0] !== 32'd1 || pop_data_q[1] !== 32'd2 ||
        checksum !== 32'd3) begin
      bad++;
      $display("FAIL abort_restart: got pops=%0d sum=%0d required 2 words 1,2 sum 3",
               pop_data_q.size(), checksum);
    end
  endtask

  task automatic test_async_reset();
    start_xfer(14'd0, 15'd8, 0);
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if ({bus.avm_chipselect, bus.st_valid, busy} !== 3'b111) begin
      bad++;
      $display("FAIL arst_pre: got %b required 111", {bus.avm_chipselect, bus.st_valid, busy});
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.avm_chipselect, bus.st_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL arst_async: got %b required 000", {bus.avm_chipselect, bus.st_valid, busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || checksum !== '0 || bus.st_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL arst_after: got busy=%b sum=%0d valid=%b required 0/0/0",
               busy, checksum, bus.st_valid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int            b = $urandom_range(0, MEMW - 1);
      int            l = $urandom_range(1, 40);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] exp_sum = '0;
      int            derr = 0, aerr = 0, max_out = 0;
      for (int i = 0; i < l; i++) begin
        mem[(b + i) % MEMW] = $urandom;
        exp_q.push_back(mem[(b + i) % MEMW]);
        exp_sum += mem[(b + i) % MEMW];
      end
      start_xfer(AW'(b), LW'(l), 1);
      wait_done(1, 1000);
      for (int i = 0; i < l; i++) begin
        if (i >= pop_data_q.size() || pop_data_q[i] !== exp_q[i]) derr++;
        if (i >= cs_addr_q.size() || cs_addr_q[i] !== AW'((b + i) % MEMW)) aerr++;
      end
      foreach (out_q[i]) if (out_q[i] > max_out) max_out = out_q[i];
      total++;
      if (derr != 0 || pop_data_q.size() != l) begin
        bad++;
        $display("FAIL rnd%0d_data: got %0d wrong, %0d words required 0 wrong, %0d words",
                 it, derr, pop_data_q.size(), l);
      end
      total++;
      if (aerr != 0 || cs_addr_q.size() != l) begin
        bad++;
        $display("FAIL rnd%0d_addr: got %0d wrong, %0d reads required 0 wrong, %0d reads",
                 it, aerr, cs_addr_q.size(), l);
      end
      total++;
      if (checksum !== exp_sum) begin
        bad++;
        $display("FAIL rnd%0d_sum: got %0d required %0d", it, checksum, exp_sum);
      end
      total++;
      if (max_out > DEPTH) begin
        bad++;
        $display("FAIL rnd%0d_credit: got %0d outstanding required <= %0d", it, max_out, DEPTH);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < MEMW; k++) mem[k] = DW'(k + 1);
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0;
    bus.st_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_zero_length();
    test_backpressure();
    test_wrap();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
